// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and bit-timing helper shared by the UART receiver and transmitter
package uart_pkg;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial pin, enable and received-byte strobes of the UART receiver
// UART_RX_PARITY_EN adds the parity-error strobe uart_rx_perr
interface uart_rx_if #(parameter int DATA_BITS = 8);
    logic                 uart_rxd;
    logic                 uart_rx_en;
    logic [DATA_BITS-1:0] uart_rx_data;
    logic                 uart_rx_valid;
    logic                 uart_rx_ferr;
    logic                 uart_rx_busy;
`ifdef UART_RX_PARITY_EN
    logic                 uart_rx_perr;
    modport master (input uart_rxd, uart_rx_en,
                    output uart_rx_data, uart_rx_valid, uart_rx_ferr, uart_rx_busy, uart_rx_perr);
    modport slave (output uart_rxd, uart_rx_en,
                   input uart_rx_data, uart_rx_valid, uart_rx_ferr, uart_rx_busy, uart_rx_perr);
`else
    modport master (input uart_rxd, uart_rx_en,
                    output uart_rx_data, uart_rx_valid, uart_rx_ferr, uart_rx_busy);
    modport slave (output uart_rxd, uart_rx_en,
                   input uart_rx_data, uart_rx_valid, uart_rx_ferr, uart_rx_busy);
`endif
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the async serial line, preset to the idle (high) level
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk) begin
        if (!reset_n) {q, meta} <= 2'b11;
        else {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, start/DATA_BITS LSB-first/stop, mid-bit sampling, valid and framing-error strobes
// UART_RX_PARITY_EN adds an even-parity bit after the data and the uart_rx_perr strobe
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8
) (
    input logic       clk,
    input logic       reset_n,
    uart_rx_if.master rx
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
`endif
    rx_state_t            state;
    logic                 rxs;
    logic                 tick;
    logic                 par_ok;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    uart_rx_sync u_sync (.clk(clk), .reset_n(reset_n), .d(rx.uart_rxd), .q(rxs));
    assign tick = cnt == '0;
`ifdef UART_RX_PARITY_EN
    logic par_err;
    logic perr_q;
    assign par_ok = !par_err;
    assign rx.uart_rx_perr = perr_q;
`else
    assign par_ok = 1'b1;
`endif
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            cnt <= tick ? cnt : cnt - 1'b1;
            case (state)
                IDLE: if (rx.uart_rx_en && !rxs) begin
                    cnt   <= HALF_BIT;
                    state <= START;
                end
                START: if (tick) begin
                    cnt     <= rxs ? '0 : FULL_BIT;
                    bit_idx <= '0;
                    state   <= rxs ? IDLE : DATA;
                end
                DATA: if (tick) begin
                    shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                    bit_idx <= bit_idx + 1'b1;
                    cnt     <= FULL_BIT;
                    state   <= bit_idx == LAST_BIT ? AFTER_DATA : DATA;
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (tick) begin
                    par_err <= (^shreg) != rxs;
                    cnt     <= FULL_BIT;
                    state   <= STOP;
                end
`endif
                // returning to IDLE here, half a bit early, lets a back-to-back start bit be caught
                STOP: if (tick) begin
                    valid_q <= rxs && par_ok;
                    ferr_q  <= !rxs;
                    data_q  <= rxs && par_ok ? shreg : data_q;
`ifdef UART_RX_PARITY_EN
                    perr_q  <= rxs && !par_ok;
`endif
                    state   <= rxs ? IDLE : WAIT_IDLE;
                end
                WAIT_IDLE: if (rxs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign rx.uart_rx_data  = data_q;
    assign rx.uart_rx_valid = valid_q;
    assign rx.uart_rx_ferr  = ferr_q;
    assign rx.uart_rx_busy  = state != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 10 clocks per bit (UART_RX_PARITY_EN adds parity cases)
module tb_uart_rx;
    localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif
    localparam int LAT = 2 + CPB / 2 + (NBITS + 1) * CPB + 1;
    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n_valid = 0;
    int   n_valid_exp = 0;
    exp_t exp_q[$];
    uart_rx_if #(.DATA_BITS(8)) rx_if ();
    uart_rx #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx(rx_if)
    );
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_if.uart_rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop);
    endtask

    // kind: 0 valid, 1 framing error, 2 parity error
    task automatic expect_strobe(input int kind, input logic [7:0] d);
        exp_q.push_back('{kind, d});
        if (kind == 0) n_valid_exp++;
    endtask

    initial begin : monitor
        int   got;
        int   n;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            n = int'(rx_if.uart_rx_valid) + int'(rx_if.uart_rx_ferr);
            got = rx_if.uart_rx_valid ? 0 : rx_if.uart_rx_ferr ? 1 : 3;
`ifdef UART_RX_PARITY_EN
            n += int'(rx_if.uart_rx_perr);
            if (got == 3 && rx_if.uart_rx_perr) got = 2;
`endif
            if (n > 1) check("strobe_excl", n, 1);
            if (n > 0) begin
                if (got == 0) n_valid++;
                if (exp_q.size() == 0) check("unexpected_strobe", got, 3);
                else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", got, e.kind);
                    if (e.kind == 0) check("rx_data", rx_if.uart_rx_data, e.data);
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        rx_if.uart_rxd = 1'b1;
        rx_if.uart_rx_en = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_data", rx_if.uart_rx_data, 0);
        check("rst_valid", rx_if.uart_rx_valid, 0);
        check("rst_ferr", rx_if.uart_rx_ferr, 0);
        check("rst_busy", rx_if.uart_rx_busy, 0);
`ifdef UART_RX_PARITY_EN
        check("rst_perr", rx_if.uart_rx_perr, 0);
`endif
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        expect_strobe(0, 8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (2) @(posedge clk);
                #1 check("busy_e2", rx_if.uart_rx_busy, 0);
                @(posedge clk);
                #1 check("busy_e3", rx_if.uart_rx_busy, 1);
                repeat (LAT - 4) @(posedge clk);
                #1 check("valid_early", rx_if.uart_rx_valid, 0);
                @(posedge clk);
                #1 check("valid_latency", rx_if.uart_rx_valid, 1);
                @(posedge clk);
                #1 check("valid_one_cycle", rx_if.uart_rx_valid, 0);
                check("busy_after_valid", rx_if.uart_rx_busy, 0);
            end
        join
        repeat (10) @(negedge clk);

        rx_if.uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        check("glitch_busy", rx_if.uart_rx_busy, 1);
        rx_if.uart_rxd = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_idle", rx_if.uart_rx_busy, 0);

        rx_if.uart_rx_en = 1'b0;
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (15) @(negedge clk);
                check("en_off_busy", rx_if.uart_rx_busy, 0);
            end
        join
        rx_if.uart_rx_en = 1'b1;
        repeat (10) @(negedge clk);

        expect_strobe(1, 8'h00);
        send_frame(8'h3C, 1'b0);
        rx_if.uart_rxd = 1'b0;
        repeat (30) @(negedge clk);
        check("break_busy", rx_if.uart_rx_busy, 1);
        rx_if.uart_rxd = 1'b1;
        repeat (20) @(negedge clk);
        check("ferr_data_hold", rx_if.uart_rx_data, 8'hA5);
        expect_strobe(0, 8'h5A);
        send_frame(8'h5A, 1'b1);
        repeat (5) @(negedge clk);

        expect_strobe(0, 8'h00);
        send_frame(8'h00, 1'b1);
        expect_strobe(0, 8'hFF);
        send_frame(8'hFF, 1'b1);
        expect_strobe(0, 8'h81);
        send_frame(8'h81, 1'b1);
        repeat (20) @(negedge clk);

        b = 8'h77;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx_if.uart_rxd = b[4];
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rx_if.uart_rxd = 1'b1;
        check("abort_busy", rx_if.uart_rx_busy, 0);
        check("abort_data", rx_if.uart_rx_data, 0);
        repeat (20) @(negedge clk);
        expect_strobe(0, 8'h12);
        send_frame(8'h12, 1'b1);
        repeat (10) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        b = 8'h07;
        expect_strobe(2, 8'h00);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(1'b0);
        drive_bit(1'b1);
        repeat (5) @(negedge clk);
        check("perr_data_hold", rx_if.uart_rx_data, 8'h12);
        expect_strobe(0, 8'h07);
        send_frame(8'h07, 1'b1);
        repeat (10) @(negedge clk);
`endif

        repeat (20) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        check("valid_count", n_valid, n_valid_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver: the receive-side counterpart of the design's existing UART transmitter.
- Frame format is 8N1 by default: start bit, DATA_BITS data bits LSB first, optional parity bit, one stop bit.
- Samples the asynchronous uart_rxd pin at mid-bit and delivers each byte with a one-cycle valid strobe.
- Reports framing error and (optionally) parity error; feeds the operand-loading path of the latch/adder system.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- DATA_BITS, 8, data bits per frame (5..8).
- CLKS_PER_BIT, CLK_HZ/BAUD (derived localparam, not overridable), clocks per bit; must be >= 4.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- uart_rxd  in  1  asynchronous serial line; idles high.
- uart_rx_en  in  1  receiver enable; sampled only in IDLE.
- uart_rx_data  out  DATA_BITS  last received byte.
- uart_rx_valid  out  1  one-cycle strobe: uart_rx_data updated with a good frame.
- uart_rx_ferr  out  1  one-cycle strobe: stop bit sampled low.
- uart_rx_busy  out  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Reset (reset_n low at a clk edge):
  - state=IDLE; all outputs 0; counters 0.
  - Synchronizer flops preset to 1 (line-idle value).
  - Reset mid-frame aborts the frame with no strobe.
- Input sync: uart_rxd passes through a 2-flop synchronizer; all logic uses the synchronized value rxs (2 cycles of latency).
- States: IDLE, START, DATA, PARITY (only with the optional feature), STOP, WAIT_IDLE.
- IDLE:
  - If uart_rx_en=1 and rxs=0: load the bit counter with CLKS_PER_BIT/2-1, go to START.
  - If uart_rx_en=0: stay in IDLE; line activity is ignored.
- START:
  - When the counter reaches 0, sample rxs.
  - rxs=0: valid start; reload CLKS_PER_BIT-1, clear the bit index, go to DATA.
  - rxs=1: glitch; return to IDLE with no strobe.
- DATA:
  - Each time the counter reaches 0: shift rxs into the shift register LSB-first and reload CLKS_PER_BIT-1.
  - After DATA_BITS samples, go to PARITY (if enabled) or STOP.
- STOP (sample at counter 0):
  - rxs=1 and no parity error: uart_rx_data<=shift register; uart_rx_valid=1 for exactly the next cycle; go to IDLE.
  - rxs=0: uart_rx_ferr=1 for one cycle; uart_rx_data unchanged; go to WAIT_IDLE.
- WAIT_IDLE: stay until rxs=1, then go to IDLE. A break condition therefore produces exactly one ferr.
- uart_rx_en dropping mid-frame does not abort; the current frame completes.
- uart_rx_data holds its value between valid strobes.
- uart_rx_valid and uart_rx_ferr are never high in the same cycle.
- Back-to-back frames: a new start bit is detectable in the cycle after returning to IDLE (half a bit before the stop bit ends), so continuous streams are received without loss.
- Latency: valid asserts 2 (sync) + CLKS_PER_BIT/2 + (DATA_BITS+1)·CLKS_PER_BIT + 1 cycles after the start-bit falling edge at the pin.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state follows DATA and samples one bit at mid-bit.
  - Expected parity is even: XOR of the data bits equals the parity bit.
  - Adds output uart_rx_perr (1 bit, reset 0): a one-cycle strobe in the cycle after the stop sample when parity mismatched.
  - On mismatch, uart_rx_valid is suppressed and uart_rx_data is unchanged.
  - If the stop bit is also low, only ferr is raised.
- Undefined: no PARITY state, no uart_rx_perr port; frame is 8N1.

Decomposition:
- Shared package uart_pkg:
  - RX state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, WAIT_IDLE=5), 3-bit state width.
  - Function/macro computing CLKS_PER_BIT from CLK_HZ and BAUD; shared with the transmitter so both ends agree.
- One sub-module: uart_rx_sync, the 2-flop synchronizer with reset value 1.
- The FSM, counters and shift register stay in uart_rx.

Test Plan:
- Test configuration: CLK_HZ=1000000, BAUD=100000 (10 clks/bit).
- Send 0xA5 as 8N1 -> one valid pulse, uart_rx_data=0xA5, ferr=0, busy high from 3 cycles after the falling edge until valid.
- Low glitch of 3 cycles on an idle line -> back to IDLE after the half-bit check; no valid, no ferr.
- Send 0x3C with the stop bit forced low, line held low for 30 cycles, then high -> exactly one ferr pulse; data keeps the prior value; next frame 0x5A received correctly.
- Back-to-back 0x00, 0xFF, 0x81 with no idle gap -> three valid pulses in order with the correct data.
- Assert reset_n=0 during data bit 4 of 0x77, release, then send 0x12 -> no strobe for the aborted frame; valid with 0x12.
- With UART_RX_PARITY_EN, send 0x07 with parity bit 0 (odd data, bad parity) -> perr pulse, no valid. Same byte with parity bit 1 -> valid, data=0x07.
